// File: rtl/serial_frame_rx_pkg.sv
// rtl/serial_frame_rx_pkg.sv - shared state encodings and defaults for the serial frame blocks
//
// Purpose: state encodings common to every serial block in this family, the default
//          data width, and the bit-counter width helper.
// Ports:   none (package).
package serial_frame_rx_pkg;

   localparam int SER_DATA_W_DEFAULT = 8;

   // Encodings are shared with the other serial blocks; do not renumber.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_PARITY = 3'd2,
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
   } ser_state_e;

   // Counter wide enough to hold 0..data_w without wrapping.
   function automatic int ser_cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/rx_sipo.sv
// rtl/rx_sipo.sv - serial-in parallel-out shift register, MSB insert, right shift
//
// Purpose: collects serial bits LSB first. Each enabled edge inserts bit_in at the
//          MSB and shifts the rest right, so after W shifts the first bit is in q[0].
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous active-low clear
//   shift_en  in  1  shift on this edge
//   bit_in    in  1  serial bit inserted at the MSB
//   q         out W  register contents
module rx_sipo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         shift_en,
   input  logic         bit_in,
   output logic [W-1:0] q
);

   logic [W-1:0] shreg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q <= '0;
      end else if (shift_en) begin
         shreg_q <= {bit_in, shreg_q[W-1:1]};
      end
   end

   assign q = shreg_q;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver with one-entry valid/ready output buffer
//
// Purpose: samples si once per clk, recognises start/data/(parity)/stop frames with
//          data LSB first, and presents each good word on a one-entry buffer.
//          Reports parity mismatch with the word, framing errors as a one-cycle
//          pulse, and a sticky overrun when a completed word finds the buffer full.
// Ports:
//   clk         in   1       rising-edge clock, si sampled every edge
//   reset       in   1       asynchronous active-low reset
//   si          in   1       serial input, idles high
//   ready       in   1       consumer takes the word when valid && ready
//   clr_ovr     in   1       synchronous pulse clearing overrun
//   data        out  DATA_W  received word, stable while valid
//   valid       out  1       buffer holds an unconsumed word
//   parity_err  out  1       parity mismatch on the buffered word
//   frame_err   out  1       one-cycle pulse, stop bit sampled low
//   overrun     out  1       sticky, a good frame was dropped
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int DATA_W    = SER_DATA_W_DEFAULT,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              si,
   input  logic              ready,
   input  logic              clr_ovr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun
);

   localparam int               CNT_W    = ser_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   ser_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              perr_q, perr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;

   logic              shift_en;
   logic              frame_good;
   logic [DATA_W-1:0] shreg;

   rx_sipo #(.W(DATA_W)) u_sipo (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .bit_in   (si),
      .q        (shreg)
   );

   // Frame sequencing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      perr_d      = perr_q;
      shift_en    = 1'b0;
      frame_good  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!si) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               perr_d  = 1'b0;
            end
         end
         ST_DATA: begin
            shift_en = 1'b1;
            if (cnt_q == LAST_BIT) begin
               cnt_d = '0;
               if (PARITY_EN != 0) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PARITY: begin
            // Even parity over data plus parity bit: any 1 means a mismatch.
            perr_d  = ^{shreg, si};
            state_d = ST_STOP;
         end
         ST_STOP: begin
            if (si) begin
               frame_good = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = ST_BREAK;
            end
         end
         ST_BREAK: begin
            // Wait for the line to return high so a held-low line is not a new start.
            if (si) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output buffer. A new word may replace a word being consumed on the same edge,
   // so valid stays high across that handoff.
   always_comb begin
      data_d       = data_q;
      valid_d      = valid_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;
      if (clr_ovr) begin
         overrun_d = 1'b0;
      end
      if (frame_good) begin
         if (!valid_q || ready) begin
            data_d       = shreg;
            parity_err_d = (PARITY_EN != 0) && perr_q;
            valid_d      = 1'b1;
         end else begin
            // Set after the clear so a coincident drop wins.
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         perr_q       <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         perr_q       <= perr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule
